counter_cmd_arbiter: RTL

COUNTER_CMD_ARBITER -- requirements
Module: counter_cmd_arbiter

---
 rtl/counter_ctrl_pkg.sv | 50 +++++
 rtl/counter_cmd_arbiter_rr_arb2.sv | 38 +++
 rtl/counter_cmd_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter command arbiter.
// Holds the command encoding, the FSM state encoding, the counter width and
// small decode helpers used when a command is issued to the counter.
// The multi-step UP/DOWN feature is selected by defining CNT_ARB_MULTI_STEP_EN.
package counter_ctrl_pkg;

  localparam int unsigned CNT_W = 5;
  localparam int unsigned CMD_W = 2;

  localparam logic [CMD_W-1:0] CMD_NOP  = 2'b00;
  localparam logic [CMD_W-1:0] CMD_UP   = 2'b01;
  localparam logic [CMD_W-1:0] CMD_DOWN = 2'b10;
  localparam logic [CMD_W-1:0] CMD_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  typedef struct packed {
    logic load;
    logic up;
    logic down;
  } strobe_t;

  // Counter strobe for one ISSUE step; saturated directions are suppressed.
  function automatic strobe_t issue_strobes(input logic [CMD_W-1:0] cmd,
                                            input logic at_high,
                                            input logic at_low);
    strobe_t s;
    s = '0;
    case (cmd)
      CMD_LOAD: s.load = 1'b1;
      CMD_UP:   s.up   = !at_high;
      CMD_DOWN: s.down = !at_low;
      default:  s      = '0;
    endcase
    return s;
  endfunction

  // True when the step would move the counter past a rail.
  function automatic logic is_refusal(input logic [CMD_W-1:0] cmd,
                                      input logic at_high,
                                      input logic at_low);
    return ((cmd == CMD_UP) && at_high) || ((cmd == CMD_DOWN) && at_low);
  endfunction

endpackage

// File: rtl/counter_cmd_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   req_i[1:0]    request vector
//   upd_en_i      commit the current grant as "last granted"
//   gnt_c_o[1:0]  combinational one-hot grant
// After reset the pointer says requester 1 was last, so requester 0 wins
// the first contention.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       upd_en_i,
  output logic [1:0] gnt_c_o
);

  logic last_q;
  logic last_d;

  // Grant decode and pointer update.
  always_comb begin
    gnt_c_o = 2'b00;
    case (req_i)
      2'b01:   gnt_c_o = 2'b01;
      2'b10:   gnt_c_o = 2'b10;
      2'b11:   gnt_c_o = last_q ? 2'b01 : 2'b10;
      default: gnt_c_o = 2'b00;
    endcase
    last_d = last_q;
    if (upd_en_i && (|req_i)) last_d = gnt_c_o[1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) last_q <= 1'b1;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/counter_cmd_arbiter.sv
// counter_cmd_arbiter: arbitrates UP/DOWN/LOAD/NOP commands from two
// requesters onto one shared 5-bit up/down counter.
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   req0/1, cmd0/1        command requests and opcodes
//   data0/1               LOAD value or UP/DOWN step count
//   ack0/1, err0/1        one-cycle completion / saturation-refusal pulses
//   busy                  high whenever the FSM is not idle
//   CNT_LOAD/UP/DOWN      registered one-cycle counter strobes
//   CNT_IN                load value to the counter
//   CNT_VAL, CNT_HIGH, CNT_LOW  counter value and rail flags
// Macro CNT_ARB_MULTI_STEP_EN: UP/DOWN repeat data times (0 counts as 1),
// stopping early on saturation. Undefined: every UP/DOWN is one step.
// All outputs are registered and line up with the FSM state: strobes are
// high during ISSUE, ack/err during DONE.
module counter_cmd_arbiter
  import counter_ctrl_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             req0,
  input  logic             req1,
  input  logic [CMD_W-1:0] cmd0,
  input  logic [CMD_W-1:0] cmd1,
  input  logic [CNT_W-1:0] data0,
  input  logic [CNT_W-1:0] data1,
  output logic             ack0,
  output logic             ack1,
  output logic             err0,
  output logic             err1,
  output logic             busy,
  output logic             CNT_LOAD,
  output logic             CNT_UP,
  output logic             CNT_DOWN,
  output logic [CNT_W-1:0] CNT_IN,
  input  logic [CNT_W-1:0] CNT_VAL,
  input  logic             CNT_HIGH,
  input  logic             CNT_LOW
);

  state_e           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic             refused_q, refused_d;
  strobe_t          stb_q, stb_d;
  logic [CNT_W-1:0] cnt_in_q, cnt_in_d;
  logic [1:0]       ack_q, ack_d;
  logic [1:0]       err_q, err_d;
  logic             busy_q, busy_d;

  logic [1:0]       arb_gnt_c;
  logic             arb_upd_c;
  logic             sel_idx_c;
  logic [CMD_W-1:0] cmd_sel_c;
  logic [CNT_W-1:0] data_sel_c;
  logic             at_high_c;
  logic             at_low_c;

  rr_arb2 u_arb (
    .clk_i    (CLK),
    .rst_i    (RST),
    .req_i    ({req1, req0}),
    .upd_en_i (arb_upd_c),
    .gnt_c_o  (arb_gnt_c)
  );

  // Requester mux driven by the arbiter grant.
  assign sel_idx_c  = arb_gnt_c[1];
  assign cmd_sel_c  = sel_idx_c ? cmd1  : cmd0;
  assign data_sel_c = sel_idx_c ? data1 : data0;

  // Rail detection also looks at the value so a lagging flag cannot let a wrap through.
  assign at_high_c = CNT_HIGH || (CNT_VAL == {CNT_W{1'b1}});
  assign at_low_c  = CNT_LOW  || (CNT_VAL == '0);

  // Next-state and registered-output decode.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    cmd_d     = cmd_q;
    steps_d   = steps_q;
    refused_d = refused_q;
    stb_d     = '0;
    cnt_in_d  = cnt_in_q;
    ack_d     = 2'b00;
    err_d     = 2'b00;
    arb_upd_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|arb_gnt_c) begin
          arb_upd_c = 1'b1;
          gnt_d     = sel_idx_c;
          cmd_d     = cmd_sel_c;
          stb_d     = issue_strobes(cmd_sel_c, at_high_c, at_low_c);
          refused_d = is_refusal(cmd_sel_c, at_high_c, at_low_c);
          if (stb_d.load) cnt_in_d = data_sel_c;
`ifdef CNT_ARB_MULTI_STEP_EN
          // steps_q counts the ISSUE steps still owed after this one.
          if (((cmd_sel_c == CMD_UP) || (cmd_sel_c == CMD_DOWN)) && (data_sel_c != '0))
            steps_d = data_sel_c - CNT_W'(1);
          else
            steps_d = '0;
`else
          steps_d = '0;
`endif
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        state_d = ST_SETTLE;
      end

      ST_SETTLE: begin
        if ((steps_q != '0) && !refused_q) begin
          stb_d     = issue_strobes(cmd_q, at_high_c, at_low_c);
          refused_d = is_refusal(cmd_q, at_high_c, at_low_c);
          steps_d   = steps_q - CNT_W'(1);
          state_d   = ST_ISSUE;
        end else begin
          ack_d   = gnt_q ? 2'b10 : 2'b01;
          err_d   = refused_q ? ack_d : 2'b00;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 1'b0;
      cmd_q     <= CMD_NOP;
      steps_q   <= '0;
      refused_q <= 1'b0;
      stb_q     <= '0;
      cnt_in_q  <= '0;
      ack_q     <= 2'b00;
      err_q     <= 2'b00;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      cmd_q     <= cmd_d;
      steps_q   <= steps_d;
      refused_q <= refused_d;
      stb_q     <= stb_d;
      cnt_in_q  <= cnt_in_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign CNT_LOAD = stb_q.load;
  assign CNT_UP   = stb_q.up;
  assign CNT_DOWN = stb_q.down;
  assign CNT_IN   = cnt_in_q;
  assign ack0     = ack_q[0];
  assign ack1     = ack_q[1];
  assign err0     = err_q[0];
  assign err1     = err_q[1];
  assign busy     = busy_q;

endmodule
